regbank_reader: RTL and testbench
=================================

Name: regbank_reader

Overview:
- Read side of the flip-flop register bank. The bank's write-enabled flip-flops are the writer; this block is the reader.
- Accepts read requests over a valid/ready handshake and samples the flattened bank contents.
- Forwards a same-cycle write (write-to-read bypass).
- Returns responses through a 2-entry skid buffer, so the downstream consumer can apply backpressure without dropping data.

Parameters:
- NREGS, 32, number of registers in the bank.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, request address width; must satisfy 2^ADDR_W >= NREGS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- regs_flat  input  NREGS*DATA_W  current bank contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_en  input  1  bank write strobe this cycle (bypass source only).
- wr_addr  input  ADDR_W  bank write address.
- wr_data  input  DATA_W  bank write data.
- req_valid  input  1  read request present.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  ADDR_W  register to read.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_data  output  DATA_W  read value.
- rsp_addr  output  ADDR_W  address of the returned value.
- rsp_err  output  1  request address was >= NREGS.

Behaviour:
- Reset (rst_n low, asynchronous): buffer count=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0. Contents of both entries cleared.
- req_ready = (count != 2). It is combinational from registered state only, with no dependence on rsp_ready. req_ready=1 immediately after reset release.
- Accept: req_valid & req_ready on a rising edge.
- Sampling on accept at edge N:
  - If req_addr >= NREGS: data=0, err=1.
  - Else if wr_en & (wr_addr==req_addr): data=wr_data (bypass; the new value wins).
  - Else: data=regs_flat[req_addr], err=0.
- Captured data is frozen. Later bank writes do not update buffered entries.
- Latency: accepted at edge N, rsp_valid=1 from edge N (visible in cycle N+1) when the buffer was empty. No combinational path from req_* to rsp_*.
- Pop: rsp_valid & rsp_ready. Outputs always present the head entry; order is strictly FIFO.
- Buffer state machine, count held in 2 bits:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, with head replaced by the new entry.
  - FULL: push is impossible (req_ready=0); pop -> ONE, second entry promoted to head.
- rsp_valid = (count != 0). rsp_data, rsp_addr and rsp_err hold stable while rsp_valid & !rsp_ready.
- Reset mid-operation: all buffered responses are discarded; no response is emitted after rst_n rises without a new request.
- Bypass uses only the same-cycle write; a write one cycle earlier is already reflected in regs_flat.

Optional Feature:
- Macro: REGBANK_ZERO_REG_EN.
- Defined: address 0 always returns data=0, err=0. Bypass is suppressed for address 0 even when wr_en & wr_addr==0.
- Undefined: address 0 behaves like any other register, including bypass.

Decomposition:
- Package regbank_pkg holds:
  - default DATA_W/ADDR_W/NREGS constants;
  - typedef rd_entry_t = struct {addr, data, err};
  - localparams BUF_DEPTH=2 and the count encodings EMPTY=0, ONE=1, FULL=2.
- Sub-module reader_skid_fifo: 2-entry FIFO of rd_entry_t with push/pop/count. The top level handles sampling, bypass, range check and the optional zero register.

Test Plan:
1. Reset release, regs_flat[3]=0xDEADBEEF, single request addr=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xDEADBEEF, rsp_addr=3, rsp_err=0; then rsp_valid=0.
2. Same-cycle write: request addr=7 with wr_en=1, wr_addr=7, wr_data=0x12345678 while regs_flat[7]=0 -> rsp_data=0x12345678.
3. Backpressure: rsp_ready=0, requests addr 1, 2, 3 back-to-back (regs = 0x11, 0x22, 0x33) -> req_ready drops after 2 accepts; addr 3 is held. Raise rsp_ready -> responses 0x11, 0x22, 0x33 in order with no loss, and outputs stable while stalled.
4. Simultaneous push/pop in ONE state, streaming 8 requests with rsp_ready=1 -> one response per cycle, count stays 1, throughput 1/cycle.
5. Out-of-range addr=40 with NREGS=32, ADDR_W=6 -> rsp_err=1, rsp_data=0.
6. Assert rst_n low with 2 entries buffered -> rsp_valid=0 asynchronously, no stale response after release. With REGBANK_ZERO_REG_EN defined, read addr 0 with wr_en=1, wr_addr=0, wr_data=0xFF -> rsp_data=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and constants for the register bank read path.
package regbank_pkg;

  localparam int DEF_NREGS  = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Response buffer depth and its occupancy encodings.
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_cnt_e;

  // One buffered read response at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
    logic                  err;
  } rd_entry_t;

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry skid FIFO holding read responses. Entry 0 is always the head.
// Push is never presented while FULL; the caller gates it with count.
module reader_skid_fifo
  import regbank_pkg::*;
#(
  parameter type entry_t = rd_entry_t
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  entry_t   push_entry,
  input  logic     pop,
  output entry_t   head,
  output buf_cnt_e count
);

  buf_cnt_e cnt_q, cnt_d;
  entry_t   ent_q [BUF_DEPTH];
  entry_t   ent_d [BUF_DEPTH];

  assign head  = ent_q[0];
  assign count = cnt_q;

  // Occupancy transitions and entry movement for push/pop combinations.
  always_comb begin
    cnt_d = cnt_q;
    ent_d = ent_q;
    case (cnt_q)
      EMPTY: begin
        if (push) begin
          ent_d[0] = push_entry;
          cnt_d    = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and the new entry takes its place in the same edge.
          ent_d[0] = push_entry;
        end else if (push) begin
          ent_d[1] = push_entry;
          cnt_d    = FULL;
        end else if (pop) begin
          cnt_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          ent_d[0] = ent_q[1];
          cnt_d    = ONE;
        end
      end
      default: cnt_d = EMPTY;
    endcase
  end

  // State register; reset discards any buffered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

endmodule

// File: rtl/regbank_reader.sv
// Read port of the flip-flop register bank: samples the flattened bank on a
// request handshake, forwards a same-cycle write, flags out-of-range
// addresses, and returns responses through a 2-entry skid FIFO.
// Optional: define REGBANK_ZERO_REG_EN to hard-wire register 0 to zero.
// ADDR_W must be wide enough to address every register (2^ADDR_W >= NREGS).
module regbank_reader
  import regbank_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ADDR_W-1:0]       rsp_addr,
  output logic                    rsp_err
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  entry_t      samp;
  entry_t      head;
  buf_cnt_e    count;
  logic        push;
  logic        pop;
  logic        in_range;
  logic [DATA_W-1:0] bank_rd;

  // Handshake terms depend only on the registered occupancy.
  assign req_ready = (count != FULL);
  assign rsp_valid = (count != EMPTY);
  assign push      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign in_range  = (int'(req_addr) < NREGS);

  // Register select from the flattened bank.
  always_comb begin
    bank_rd = '0;
    for (int i = 0; i < NREGS; i++)
      if (int'(req_addr) == i) bank_rd = regs_flat[i*DATA_W +: DATA_W];
  end

  // Build the response captured on accept: range check, zero register,
  // then same-cycle write forwarding, then the bank value.
  always_comb begin
    samp      = '0;
    samp.addr = req_addr;
    if (!in_range) begin
      samp.err = 1'b1;
`ifdef REGBANK_ZERO_REG_EN
    end else if (req_addr == '0) begin
      samp.data = '0;
`endif
    end else if (wr_en && (wr_addr == req_addr)) begin
      samp.data = wr_data;
    end else begin
      samp.data = bank_rd;
    end
  end

  reader_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (samp),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign rsp_data = head.data;
  assign rsp_addr = head.addr;
  assign rsp_err  = head.err;

endmodule

// File: tb/tb_regbank_reader.sv
// Self-checking bench for regbank_reader: directed scenarios with literal
// expectations plus a randomized phase, all compared each cycle against a
// queue-based response model and a bench-owned register bank.
module tb_regbank_reader;

  localparam int NREGS  = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREGS*DATA_W-1:0] regs_flat;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [ADDR_W-1:0]       rsp_addr;
  logic                    rsp_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic [DATA_W-1:0] bank [NREGS];
  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

`ifdef REGBANK_ZERO_REG_EN
  localparam logic [DATA_W-1:0] ZERO_EXP = 32'h0;
`else
  localparam logic [DATA_W-1:0] ZERO_EXP = 32'hFF;
`endif

  always #5 clk = ~clk;

  regbank_reader #(
    .NREGS  (NREGS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err)
  );

  // Bench-owned bank: the writer side the reader observes.
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = bank[g];
  end

  always @(posedge clk)
    if (wr_en && (int'(wr_addr) < NREGS)) bank[wr_addr[4:0]] <= wr_data;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // What a read of address a must return given the pre-edge bank and write.
  function automatic exp_t model_read(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.addr = a;
    e.data = '0;
    e.err  = 1'b0;
    if (int'(a) >= NREGS) e.err = 1'b1;
`ifdef REGBANK_ZERO_REG_EN
    else if (a == '0) e.data = '0;
`endif
    else if (wr_en && (wr_addr == a)) e.data = wr_data;
    else e.data = bank[a[4:0]];
    return e;
  endfunction

  // Response model: an ordered queue of at most two pending responses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit take;
      take = req_valid && (q.size() < 2);
      if ((q.size() != 0) && rsp_ready) q.delete(0);
      if (take) q.push_back(model_read(req_addr));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
    check("req_ready", 64'(req_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("rsp_data", 64'(rsp_data), 64'(q[0].data));
      check("rsp_addr", 64'(rsp_addr), 64'(q[0].addr));
      check("rsp_err",  64'(rsp_err),  64'(q[0].err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

    // Preload the bank while the reader is held in reset.
    for (int i = 0; i < NREGS; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = $urandom;
      if (i == 3) wr_data = 32'hDEADBEEF;
      if (i == 7) wr_data = 32'h0;
      step();
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_data",  64'(rsp_data),  64'd0);
    check("reset_addr",  64'(rsp_addr),  64'd0);
    check("reset_err",   64'(rsp_err),   64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);

    // Single read, one-cycle latency, then drained.
    req_valid = 1'b1; req_addr = 6'd3;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_data",  64'(rsp_data),  64'hDEADBEEF);
    check("t1_addr",  64'(rsp_addr),  64'd3);
    check("t1_err",   64'(rsp_err),   64'd0);
    step();
    @(negedge clk);
    check("t1_drained", 64'(rsp_valid), 64'd0);

    // Same-cycle write is forwarded.
    req_valid = 1'b1; req_addr = 6'd7;
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'h12345678;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("t2_bypass", 64'(rsp_data), 64'h12345678);
    step();

    // Backpressure: two accepts fill the buffer, third request waits.
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = 32'(i * 'h11);
      step();
    end
    wr_en = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 6'd1;
    step();
    req_addr = 6'd2;
    step();
    req_addr = 6'd3;
    @(negedge clk);
    check("t3_full_ready", 64'(req_ready), 64'd0);
    repeat (3) step();
    @(negedge clk);
    check("t3_stall_data", 64'(rsp_data), 64'h11);
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("t3_second", 64'(rsp_data), 64'h22);
    check("t3_ready_back", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t3_third", 64'(rsp_data), 64'h33);
    check("t3_third_addr", 64'(rsp_addr), 64'd3);
    step();
    @(negedge clk);
    check("t3_drained", 64'(rsp_valid), 64'd0);

    // Streaming at one response per cycle.
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_addr  = ADDR_W'($urandom_range(0, NREGS - 1));
      step();
      @(negedge clk);
      check("t4_stream_valid", 64'(rsp_valid), 64'd1);
      check("t4_stream_ready", 64'(req_ready), 64'd1);
    end
    req_valid = 1'b0;
    step();

    // Out-of-range address.
    req_valid = 1'b1; req_addr = 6'd40;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t5_err",  64'(rsp_err),  64'd1);
    check("t5_data", 64'(rsp_data), 64'd0);
    check("t5_addr", 64'(rsp_addr), 64'd40);
    step();

    // Asynchronous reset with two responses buffered.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 6'd5;
    step();
    req_addr = 6'd6;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_buffered", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_stale", 64'(rsp_valid), 64'd0);
    end
    step();

    // Register 0 with a same-cycle write.
    req_valid = 1'b1; req_addr = 6'd0;
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'hFF;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("t6_zero_reg", 64'(rsp_data), 64'(ZERO_EXP));
    step();

    // Randomized traffic with writes aimed at the requested register.
    for (int k = 0; k < 400; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom_range(0, NREGS + 3));
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_addr   = ($urandom_range(0, 1) == 1) ? req_addr : ADDR_W'($urandom_range(0, NREGS - 1));
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("final_drained", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
